// File: rtl/hazard_controller_pkg.sv
// hazard_controller_pkg
//   Shared constants and types for the pipeline hazard controller:
//   register-file address width, FSM state encoding and its width.
package hazard_controller_pkg;

   localparam int unsigned REGISTER_FILE_ADDRESS_LEN = 4;
   localparam int unsigned STATE_W                   = 2;

   // Encoding is visible on the state port and must stay RUN=0, MEM_WAIT=1, ERROR=2.
   typedef enum logic [STATE_W-1:0] {
      StRun     = 2'd0,
      StMemWait = 2'd1,
      StError   = 2'd2
   } state_t;

endpackage

// File: rtl/hazard_controller_hazard_detect.sv
// hazard_controller_hazard_detect
//   Pure combinational data-hazard term for the ID stage.
//   Ports:
//     i_forwarding_enable        forwarding path active (only load-use stalls)
//     i_id_valid                 ID holds a real instruction
//     i_src1, i_src2, i_two_src  ID source registers; src2 counts only if i_two_src
//     i_exe_dest, i_exe_wb_en    EXE destination and write-back enable
//     i_mem_dest, i_mem_wb_en    MEM destination and write-back enable
//     i_exe_mem_read             EXE holds a load
//     o_hazard                   stall required for a hazard forwarding cannot cover
module hazard_controller_hazard_detect #(
   parameter int unsigned REG_ADDR_W = 4
) (
   input  logic                  i_forwarding_enable,
   input  logic                  i_id_valid,
   input  logic [REG_ADDR_W-1:0] i_src1,
   input  logic [REG_ADDR_W-1:0] i_src2,
   input  logic                  i_two_src,
   input  logic [REG_ADDR_W-1:0] i_exe_dest,
   input  logic [REG_ADDR_W-1:0] i_mem_dest,
   input  logic                  i_exe_wb_en,
   input  logic                  i_mem_wb_en,
   input  logic                  i_exe_mem_read,
   output logic                  o_hazard
);

   logic w_raw_exe;
   logic w_raw_mem;

   assign w_raw_exe = i_exe_wb_en &&
                      ((i_exe_dest == i_src1) || (i_two_src && (i_exe_dest == i_src2)));
   assign w_raw_mem = i_mem_wb_en &&
                      ((i_mem_dest == i_src1) || (i_two_src && (i_mem_dest == i_src2)));

   // With forwarding, only a load in EXE cannot be bypassed in time.
   assign o_hazard = i_id_valid &&
                     (i_forwarding_enable ? (i_exe_mem_read && w_raw_exe)
                                          : (w_raw_exe || w_raw_mem));

endmodule

// File: rtl/hazard_controller.sv
// hazard_controller
//   Pipeline sequencing: IF/ID hold, ID/EXE bubble, IF/ID flush on taken
//   branch, and whole-pipeline freeze while the SRAM-backed MEM stage waits,
//   with a timeout that locks into an error state until reset.
//   Ports:
//     clk, rst                        clock, asynchronous active-high reset
//     forwarding_enable .. exe_mem_read   hazard-detection inputs
//     branch_taken                    EXE resolved a taken branch
//     mem_req, sram_ready             MEM access in progress / completes now
//     hazard_freeze, id_bubble, if_flush, pipe_freeze   combinational controls
//     mem_error                       sticky SRAM timeout flag
//     state                           FSM state (RUN=0, MEM_WAIT=1, ERROR=2)
//     stall_cycles                    saturating count of hazard_freeze cycles
module hazard_controller
   import hazard_controller_pkg::*;
#(
   parameter int unsigned REG_ADDR_W   = REGISTER_FILE_ADDRESS_LEN,
   parameter int unsigned COUNT_W      = 16,
   parameter int unsigned SRAM_TIMEOUT = 64
) (
   input  logic                  clk,
   input  logic                  rst,
   input  logic                  forwarding_enable,
   input  logic                  id_valid,
   input  logic [REG_ADDR_W-1:0] src1,
   input  logic [REG_ADDR_W-1:0] src2,
   input  logic                  two_src,
   input  logic [REG_ADDR_W-1:0] exe_dest,
   input  logic [REG_ADDR_W-1:0] mem_dest,
   input  logic                  exe_wb_en,
   input  logic                  mem_wb_en,
   input  logic                  exe_mem_read,
   input  logic                  branch_taken,
   input  logic                  mem_req,
   input  logic                  sram_ready,
   output logic                  hazard_freeze,
   output logic                  id_bubble,
   output logic                  if_flush,
   output logic                  pipe_freeze,
   output logic                  mem_error,
   output logic [STATE_W-1:0]    state,
   output logic [COUNT_W-1:0]    stall_cycles
);

   localparam int unsigned WAIT_W = (SRAM_TIMEOUT > 1) ? $clog2(SRAM_TIMEOUT) : 1;
   localparam logic [WAIT_W-1:0] WAIT_LAST = WAIT_W'(SRAM_TIMEOUT - 1);

   state_t              r_state, w_state_d;
   logic [WAIT_W-1:0]   r_wait, w_wait_d;
   logic                r_mem_error, w_mem_error_d;
   logic [COUNT_W-1:0]  r_stall;
   logic                w_hazard;

   hazard_controller_hazard_detect #(
      .REG_ADDR_W(REG_ADDR_W)
   ) u_hazard_detect (
      .i_forwarding_enable(forwarding_enable),
      .i_id_valid         (id_valid),
      .i_src1             (src1),
      .i_src2             (src2),
      .i_two_src          (two_src),
      .i_exe_dest         (exe_dest),
      .i_mem_dest         (mem_dest),
      .i_exe_wb_en        (exe_wb_en),
      .i_mem_wb_en        (mem_wb_en),
      .i_exe_mem_read     (exe_mem_read),
      .o_hazard           (w_hazard)
   );

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_state     <= StRun;
         r_wait      <= '0;
         r_mem_error <= 1'b0;
         r_stall     <= '0;
      end else begin
         r_state     <= w_state_d;
         r_wait      <= w_wait_d;
         r_mem_error <= w_mem_error_d;
         if (hazard_freeze && (r_stall != '1)) begin
            r_stall <= r_stall + COUNT_W'(1);
         end
      end
   end

   always_comb begin
      w_state_d     = r_state;
      w_wait_d      = r_wait;
      w_mem_error_d = r_mem_error;
      case (r_state)
         StRun: begin
            if (mem_req && !sram_ready) begin
               w_state_d = StMemWait;
               w_wait_d  = '0;
            end
         end
         StMemWait: begin
            if (sram_ready) begin
               w_state_d = StRun;
            end else if (r_wait == WAIT_LAST) begin
               w_state_d     = StError;
               w_mem_error_d = 1'b1;
            end else begin
               w_wait_d = r_wait + WAIT_W'(1);
            end
         end
         StError: begin
            w_state_d = StError;
         end
         default: begin
            w_state_d = StRun;
         end
      endcase
   end

   // Priority: memory freeze, then taken branch, then data hazard.
   always_comb begin
      hazard_freeze = 1'b0;
      id_bubble     = 1'b0;
      if_flush      = 1'b0;
      // The MEM_WAIT cycle that sees sram_ready lets the pipeline move.
      pipe_freeze   = ((mem_req && !sram_ready) || (r_state != StRun)) &&
                      !((r_state == StMemWait) && sram_ready);
      if (pipe_freeze) begin
         hazard_freeze = 1'b1;
      end else if (branch_taken) begin
         if_flush  = 1'b1;
         id_bubble = 1'b1;
      end else begin
         hazard_freeze = w_hazard;
         id_bubble     = w_hazard;
      end
   end

   assign state        = r_state;
   assign mem_error    = r_mem_error;
   assign stall_cycles = r_stall;

endmodule

// File: tb/tb_hazard_controller.sv
module tb_hazard_controller;

   localparam int unsigned REG_ADDR_W   = 4;
   localparam int unsigned COUNT_W      = 3;
   localparam int unsigned SRAM_TIMEOUT = 4;
   localparam int          CNT_MAX      = (1 << COUNT_W) - 1;

   logic                  clk = 1'b0;
   logic                  rst;
   logic                  forwarding_enable, id_valid, two_src;
   logic [REG_ADDR_W-1:0] src1, src2, exe_dest, mem_dest;
   logic                  exe_wb_en, mem_wb_en, exe_mem_read, branch_taken;
   logic                  mem_req, sram_ready;
   logic                  hazard_freeze, id_bubble, if_flush, pipe_freeze, mem_error;
   logic [1:0]            state;
   logic [COUNT_W-1:0]    stall_cycles;

   int n_cmp  = 0;
   int n_fail = 0;

   // Reference model: mode 0=run, 1=waiting on memory, 2=error.
   int m_mode, m_wait, m_stall;
   bit m_err;

   always #5 clk = ~clk;

   hazard_controller #(
      .REG_ADDR_W  (REG_ADDR_W),
      .COUNT_W     (COUNT_W),
      .SRAM_TIMEOUT(SRAM_TIMEOUT)
   ) dut (
      .clk              (clk),
      .rst              (rst),
      .forwarding_enable(forwarding_enable),
      .id_valid         (id_valid),
      .src1             (src1),
      .src2             (src2),
      .two_src          (two_src),
      .exe_dest         (exe_dest),
      .mem_dest         (mem_dest),
      .exe_wb_en        (exe_wb_en),
      .mem_wb_en        (mem_wb_en),
      .exe_mem_read     (exe_mem_read),
      .branch_taken     (branch_taken),
      .mem_req          (mem_req),
      .sram_ready       (sram_ready),
      .hazard_freeze    (hazard_freeze),
      .id_bubble        (id_bubble),
      .if_flush         (if_flush),
      .pipe_freeze      (pipe_freeze),
      .mem_error        (mem_error),
      .state            (state),
      .stall_cycles     (stall_cycles)
   );

   function automatic bit reads(input bit wb, input int dest);
      return wb && ((dest == int'(src1)) || (two_src && dest == int'(src2)));
   endfunction

   // Expected combinational outputs from the current inputs and model mode.
   function automatic void model_out(output bit pf, output bit hf, output bit bub,
                                     output bit fl);
      bit hz;
      if (forwarding_enable)
         hz = id_valid && exe_mem_read && reads(exe_wb_en, int'(exe_dest));
      else
         hz = id_valid && (reads(exe_wb_en, int'(exe_dest)) ||
                           reads(mem_wb_en, int'(mem_dest)));
      if (m_mode == 1 && sram_ready) pf = 0;
      else                           pf = (mem_req && !sram_ready) || (m_mode != 0);
      hf = 0; bub = 0; fl = 0;
      if (pf)                hf = 1;
      else if (branch_taken) begin fl = 1; bub = 1; end
      else                   begin hf = hz; bub = hz; end
   endfunction

   task automatic model_advance();
      bit pf, hf, bub, fl;
      model_out(pf, hf, bub, fl);
      if (hf && m_stall < CNT_MAX) m_stall++;
      if (m_mode == 0) begin
         if (mem_req && !sram_ready) begin m_mode = 1; m_wait = 1; end
      end else if (m_mode == 1) begin
         if (sram_ready) m_mode = 0;
         else if (m_wait == SRAM_TIMEOUT) begin m_mode = 2; m_err = 1; end
         else m_wait++;
      end
   endtask

   task automatic tick();
      @(posedge clk);
      model_advance();
      #1;
   endtask

   task automatic idle_inputs();
      forwarding_enable = 0; id_valid = 0; two_src = 0;
      src1 = 0; src2 = 0; exe_dest = 0; mem_dest = 0;
      exe_wb_en = 0; mem_wb_en = 0; exe_mem_read = 0; branch_taken = 0;
      mem_req = 0; sram_ready = 0;
   endtask

   task automatic do_reset();
      rst = 1;
      m_mode = 0; m_wait = 0; m_stall = 0; m_err = 0;
      @(posedge clk);
      #1 rst = 0;
   endtask

   task automatic test_reset();
      idle_inputs();
      rst = 1;
      #2;
      n_cmp++; if (state !== 2'd0) begin n_fail++;
         $display("FAIL reset_state: got %0d expected 0", state); end
      n_cmp++; if (mem_error !== 1'b0) begin n_fail++;
         $display("FAIL reset_mem_error: got %0b expected 0", mem_error); end
      n_cmp++; if (stall_cycles !== '0) begin n_fail++;
         $display("FAIL reset_stall: got %0d expected 0", stall_cycles); end
      n_cmp++; if ({pipe_freeze, hazard_freeze, id_bubble, if_flush} !== 4'b0) begin n_fail++;
         $display("FAIL reset_outputs: got %b expected 0000",
                  {pipe_freeze, hazard_freeze, id_bubble, if_flush}); end
      do_reset();
   endtask

   task automatic test_load_use();
      do_reset();
      idle_inputs();
      forwarding_enable = 1; id_valid = 1; src1 = 3; src2 = 9;
      exe_dest = 3; exe_wb_en = 1; exe_mem_read = 1;
      #1;
      n_cmp++; if ({hazard_freeze, id_bubble} !== 2'b11) begin n_fail++;
         $display("FAIL load_use_stall: got %b expected 11", {hazard_freeze, id_bubble}); end
      n_cmp++; if (stall_cycles !== 3'd0) begin n_fail++;
         $display("FAIL load_use_cnt0: got %0d expected 0", stall_cycles); end
      tick();
      exe_mem_read = 0; exe_wb_en = 0; // load left EXE
      #1;
      n_cmp++; if ({hazard_freeze, id_bubble} !== 2'b00) begin n_fail++;
         $display("FAIL load_use_release: got %b expected 00", {hazard_freeze, id_bubble}); end
      n_cmp++; if (stall_cycles !== 3'd1) begin n_fail++;
         $display("FAIL load_use_cnt1: got %0d expected 1", stall_cycles); end
      // Forwarded ALU result in EXE needs no stall.
      exe_wb_en = 1;
      #1;
      n_cmp++; if (hazard_freeze !== 1'b0) begin n_fail++;
         $display("FAIL fwd_alu_nostall: got %0b expected 0", hazard_freeze); end
   endtask

   task automatic test_two_src();
      do_reset();
      idle_inputs();
      id_valid = 1; src1 = 1; src2 = 5; mem_dest = 5; mem_wb_en = 1; exe_dest = 7;
      two_src = 0;
      #1;
      n_cmp++; if (hazard_freeze !== 1'b0) begin n_fail++;
         $display("FAIL two_src0: got %0b expected 0", hazard_freeze); end
      two_src = 1;
      #1;
      n_cmp++; if ({hazard_freeze, id_bubble} !== 2'b11) begin n_fail++;
         $display("FAIL two_src1: got %b expected 11", {hazard_freeze, id_bubble}); end
      id_valid = 0;
      #1;
      n_cmp++; if (hazard_freeze !== 1'b0) begin n_fail++;
         $display("FAIL id_invalid: got %0b expected 0", hazard_freeze); end
   endtask

   task automatic test_branch();
      do_reset();
      idle_inputs();
      forwarding_enable = 1; id_valid = 1; src1 = 2; exe_dest = 2;
      exe_wb_en = 1; exe_mem_read = 1; branch_taken = 1;
      #1;
      n_cmp++; if ({if_flush, id_bubble, hazard_freeze} !== 3'b110) begin n_fail++;
         $display("FAIL branch_over_hazard: got %b expected 110",
                  {if_flush, id_bubble, hazard_freeze}); end
      // A pending memory freeze holds the branch back.
      mem_req = 1;
      #1;
      n_cmp++; if ({pipe_freeze, hazard_freeze, if_flush, id_bubble} !== 4'b1100) begin
         n_fail++;
         $display("FAIL branch_frozen: got %b expected 1100",
                  {pipe_freeze, hazard_freeze, if_flush, id_bubble}); end
   endtask

   task automatic test_mem_wait();
      do_reset();
      idle_inputs();
      mem_req = 1;
      for (int i = 0; i < 3; i++) begin
         #1;
         n_cmp++; if (pipe_freeze !== 1'b1) begin n_fail++;
            $display("FAIL wait_freeze%0d: got %0b expected 1", i, pipe_freeze); end
         n_cmp++; if (state !== ((i == 0) ? 2'd0 : 2'd1)) begin n_fail++;
            $display("FAIL wait_state%0d: got %0d expected %0d", i, state, (i == 0) ? 0 : 1); end
         tick();
      end
      sram_ready = 1;
      #1;
      n_cmp++; if ({pipe_freeze, hazard_freeze} !== 2'b00) begin n_fail++;
         $display("FAIL ready_unfrozen: got %b expected 00", {pipe_freeze, hazard_freeze}); end
      tick();
      mem_req = 0;
      #1;
      n_cmp++; if (state !== 2'd0) begin n_fail++;
         $display("FAIL wait_back_run: got %0d expected 0", state); end
      n_cmp++; if (stall_cycles !== 3'd3) begin n_fail++;
         $display("FAIL wait_stall_cnt: got %0d expected 3", stall_cycles); end
   endtask

   task automatic test_timeout();
      do_reset();
      idle_inputs();
      mem_req = 1;
      tick();
      for (int i = 1; i <= SRAM_TIMEOUT; i++) begin
         n_cmp++; if ({state, mem_error} !== {2'd1, 1'b0}) begin n_fail++;
            $display("FAIL timeout_wait%0d: got state %0d err %0b expected 1 0",
                     i, state, mem_error); end
         tick();
      end
      mem_req = 0;
      #1;
      n_cmp++; if ({state, mem_error, pipe_freeze} !== {2'd2, 1'b1, 1'b1}) begin n_fail++;
         $display("FAIL timeout_error: got state %0d err %0b pf %0b expected 2 1 1",
                  state, mem_error, pipe_freeze); end
      sram_ready = 1;
      tick();
      n_cmp++; if ({state, pipe_freeze} !== {2'd2, 1'b1}) begin n_fail++;
         $display("FAIL error_held: got state %0d pf %0b expected 2 1", state, pipe_freeze); end
      rst = 1;
      #1;
      n_cmp++; if ({state, mem_error} !== {2'd0, 1'b0}) begin n_fail++;
         $display("FAIL error_async_reset: got state %0d err %0b expected 0 0",
                  state, mem_error); end
      do_reset();
   endtask

   task automatic test_saturate();
      do_reset();
      idle_inputs();
      id_valid = 1; src1 = 6; exe_dest = 6; exe_wb_en = 1;
      for (int i = 1; i <= 10; i++) begin
         tick();
         n_cmp++; if (int'(stall_cycles) !== ((i < CNT_MAX) ? i : CNT_MAX)) begin n_fail++;
            $display("FAIL saturate%0d: got %0d expected %0d", i, stall_cycles,
                     (i < CNT_MAX) ? i : CNT_MAX); end
      end
   endtask

   task automatic test_random();
      bit pf, hf, bub, fl;
      do_reset();
      for (int c = 0; c < 400; c++) begin
         if ($urandom_range(59) == 0) do_reset();
         forwarding_enable = 1'($urandom);
         id_valid          = ($urandom_range(3) != 0);
         src1              = REG_ADDR_W'($urandom_range(3));
         src2              = REG_ADDR_W'($urandom_range(3));
         two_src           = 1'($urandom);
         exe_dest          = REG_ADDR_W'($urandom_range(3));
         mem_dest          = REG_ADDR_W'($urandom_range(3));
         exe_wb_en         = 1'($urandom);
         mem_wb_en         = 1'($urandom);
         exe_mem_read      = 1'($urandom);
         branch_taken      = ($urandom_range(4) == 0);
         mem_req           = ($urandom_range(3) == 0);
         sram_ready        = ($urandom_range(2) != 0);
         #1;
         model_out(pf, hf, bub, fl);
         n_cmp++;
         if ({pipe_freeze, hazard_freeze, id_bubble, if_flush} !== {pf, hf, bub, fl}) begin
            n_fail++;
            $display("FAIL rand_ctrl@%0d: got %b expected %b", c,
                     {pipe_freeze, hazard_freeze, id_bubble, if_flush}, {pf, hf, bub, fl});
         end
         n_cmp++;
         if ({int'(state), int'(mem_error), int'(stall_cycles)} !==
             {m_mode, int'(m_err), m_stall}) begin
            n_fail++;
            $display("FAIL rand_regs@%0d: got st %0d err %0b cnt %0d expected %0d %0b %0d",
                     c, state, mem_error, stall_cycles, m_mode, m_err, m_stall);
         end
         tick();
      end
   endtask

   initial begin
      rst = 1;
      idle_inputs();
      test_reset();
      test_load_use();
      test_two_src();
      test_branch();
      test_mem_wait();
      test_timeout();
      test_saturate();
      test_random();
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
      $finish;
   end

endmodule
